// File: rtl/uncache_pkg.sv
// Shared types for the uncached-access bridge: read FSM encoding and reset constants.
package uncache_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_DRAIN   = 4'b0010,
    ST_RD_WAIT = 4'b0100,
    ST_RD_DONE = 4'b1000
  } rd_state_e;

  localparam rd_state_e RST_STATE      = ST_IDLE;
  localparam logic      RST_AXI_EN     = 1'b0;

endpackage

// File: rtl/uncache_wbuf_fifo.sv
// Posted-write FIFO: registered count, pointers wrap modulo DEPTH, head is the oldest entry.
module uncache_wbuf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uncache_wb.sv
// Uncached-access bridge: posted writes through a FIFO, reads drain the FIFO then issue,
// one outstanding bus request at a time.
module uncache_wb
  import uncache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STRB_W     = DATA_W/8,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              stallreq,
  input  logic              conf_en,
  input  logic [STRB_W-1:0] conf_wen,
  input  logic [ADDR_W-1:0] conf_addr,
  input  logic [DATA_W-1:0] conf_wdata,
  output logic [DATA_W-1:0] conf_rdata,
  output logic              axi_en,
  output logic [STRB_W-1:0] axi_wsel,
  output logic [ADDR_W-1:0] axi_addr,
  output logic [DATA_W-1:0] axi_wdata,
  input  logic              reload,
  input  logic [DATA_W-1:0] axi_rdata,
  output logic              wbuf_empty
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] wen;
    logic [DATA_W-1:0] wdata;
  } wbuf_entry_t;

  localparam int ENTRY_W = $bits(wbuf_entry_t);
  localparam int CNT_W   = $clog2(WBUF_DEPTH) + 1;

  rd_state_e   state;
  rd_state_e   state_nxt;
  wbuf_entry_t push_entry;
  wbuf_entry_t fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic        is_rd;
  logic        is_wr;
  logic        push;
  logic        pop;
  logic        rd_issue;
  logic        bus_done;

  assign is_rd    = conf_en & ~(|conf_wen);
  assign is_wr    = conf_en & (|conf_wen);
  assign bus_done = reload & axi_en;
  assign push     = is_wr & ~fifo_full & (state == ST_IDLE);
  // Writes go out whenever the bus is free unless a read already owns it.
  assign pop      = ~axi_en & ~fifo_empty & ((state == ST_IDLE) | (state == ST_DRAIN));
  assign rd_issue = ~axi_en & fifo_empty &
                    (((state == ST_IDLE) & is_rd) | (state == ST_DRAIN));

  assign push_entry = '{addr: conf_addr, wen: conf_wen, wdata: conf_wdata};

  uncache_wbuf_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (WBUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RST_STATE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stallreq  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        stallreq = is_rd | (is_wr & fifo_full);
        if (is_rd) state_nxt = rd_issue ? ST_RD_WAIT : ST_DRAIN;
      end
      ST_DRAIN: begin
        stallreq = 1'b1;
        if (rd_issue) state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        stallreq = 1'b1;
        if (bus_done) state_nxt = ST_RD_DONE;
      end
      // The retiring read is still on conf_*; it must not be re-issued.
      ST_RD_DONE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Bus request registers: cleared on completion, loaded only while the bus is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      axi_en    <= RST_AXI_EN;
      axi_wsel  <= '0;
      axi_addr  <= '0;
      axi_wdata <= '0;
    end else if (bus_done) begin
      axi_en    <= 1'b0;
      axi_wsel  <= '0;
      axi_addr  <= '0;
      axi_wdata <= '0;
    end else if (pop) begin
      axi_en    <= 1'b1;
      axi_wsel  <= fifo_head.wen;
      axi_addr  <= fifo_head.addr;
      axi_wdata <= fifo_head.wdata;
    end else if (rd_issue) begin
      axi_en    <= 1'b1;
      axi_wsel  <= '0;
      axi_addr  <= conf_addr;
      axi_wdata <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   conf_rdata <= '0;
    else if (bus_done && state == ST_RD_WAIT)   conf_rdata <= axi_rdata;
  end

  assign wbuf_empty = (fifo_count == '0) & ~(axi_en & (|axi_wsel));

endmodule
